sfifo_ram_mc_meta: RTL and testbench
====================================

# sfifo_ram_mc_meta

Multi-channel synchronous metadata FIFO: NUM_CH independent logical FIFOs share one RAM, partitioned into fixed per-channel regions of 2^DEPTH_NBITS entries each. It is the parametrised successor of the single-channel lh_ecdsa metadata FIFO and is used where per-traffic-class queuing of packet metadata (ECDSA, forwarding) is needed ahead of a channel scheduler. Payload width is generic (packed metadata vector). Per-channel status, a programmable almost-full threshold and sticky overflow/underflow errors are provided.

## Interface
- WIDTH, `LH_ECDSA_META_NBITS: payload width in bits
- NUM_CH, 4: number of logical channels (power of two)
- CH_NBITS, 2: log2(NUM_CH)
- DEPTH_NBITS, 9: log2 of per-channel depth; DEPTH = 1<<DEPTH_NBITS
- PFULL_MARGIN, 8: pfull asserts when count >= DEPTH-PFULL_MARGIN
- clk  in  1  clock; single clock domain
- `RESET_SIG  in  1  reset; synchronous, active-high
- wr  in  1  write strobe
- wr_ch  in  CH_NBITS  target channel of write
- din  in  WIDTH  write data
- rd  in  1  read strobe
- rd_ch  in  CH_NBITS  source channel of read
- dout  out  WIDTH  read data, registered
- dout_valid  out  1  dout holds data of an accepted read
- dout_ch  out  CH_NBITS  channel of the data on dout
- count  out  NUM_CH*(DEPTH_NBITS+1)  per-channel occupancy, channel c at bits [c*(DEPTH_NBITS+1) +: DEPTH_NBITS+1]
- empty  out  NUM_CH  per-channel count==0
- full  out  NUM_CH  per-channel count==DEPTH
- pfull  out  NUM_CH  per-channel almost full
- ovf_err  out  1  sticky: write to full channel occurred
- udf_err  out  1  sticky: read from empty channel occurred

## Operation
- RAM: NUM_CH*DEPTH x WIDTH, address {ch, ptr}; one write port, one read port, read-first.
- Per channel: wptr, rptr (DEPTH_NBITS, wrap DEPTH-1 -> 0), count (DEPTH_NBITS+1).
- Write accepted iff wr && !full[wr_ch]: RAM[{wr_ch,wptr}] <= din, wptr++.
- Write to full channel: dropped, no state change, ovf_err set.
- Read accepted iff rd && !empty[rd_ch]: rptr++, data appears on dout next cycle.
- Read of empty channel: dropped, udf_err set, dout_valid low next cycle.
- No write-to-read bypass: read of an empty channel with simultaneous write to same channel is an underflow; write still accepted.
- Accepted write and read on same channel in one cycle: count unchanged, both pointers advance.
- Full channel, rd and wr same channel same cycle: read accepted, write dropped (full evaluated on pre-cycle count), ovf_err set.
- Different channels on wr/rd: fully independent.
- Flags derive combinationally from registered count; no flag depends on current-cycle wr/rd.
- ovf_err/udf_err clear only on reset.

## Timing
- Reset values: all pointers/counts 0, empty all-ones, full 0, pfull 0 (unless DEPTH-PFULL_MARGIN<=0, disallowed), dout_valid 0, dout_ch 0, ovf_err 0, udf_err 0; dout undefined (RAM not reset).
- Reset mid-operation: all channels emptied next cycle; in-flight read discarded (dout_valid 0).
- Write-to-visible: count/empty update 1 cycle after wr; data readable by a rd issued that next cycle.
- Read latency: 1 cycle rd -> dout/dout_valid/dout_ch; dout_valid is a 1-cycle pulse per accepted read; back-to-back reads give one word per cycle.
- Throughput: 1 write + 1 read per cycle.

## Structure
- meta_package: lh_ecdsa_meta_type and width constant already present; wrappers pack/unpack the struct to WIDTH outside this block.
- Sub-module sfifo_mc_chan_ctrl: one per channel (generate), holds wptr/rptr/count, outputs empty/full/pfull and accept strobes.
- RAM array carries (* ram_style = "ultra" *).

## Test plan
- Reset, write ch2 values 0xA,0xB, read ch2 twice -> dout 0xA then 0xB, dout_ch=2, count[ch2] 2->0, empty[2]=1.
- Fill ch0 with 512 writes (DEPTH_NBITS=9) -> full[0]=1, pfull[0] at count 504; 513th write dropped, ovf_err=1, other channels unaffected.
- Read empty ch1 -> udf_err=1, dout_valid=0; same cycle write ch1 0x5 -> count[ch1]=1, next read returns 0x5.
- Interleave wr ch3/rd ch3 every cycle for 2000 cycles with count=3 -> count stays 3, data order preserved across pointer wrap.
- Full ch0, wr+rd ch0 same cycle -> read returns oldest, write dropped, count 511, ovf_err=1.
- Assert reset with 10 entries in ch1 and rd in flight -> next cycle all empty, dout_valid=0, errors cleared.

Source files
------------

// File: rtl/sfifo_ram_mc_meta_pkg.sv
// Shared constants and helpers for the multi-channel metadata FIFO.
// The payload is an opaque packed vector whose width comes from the metadata definition.
package sfifo_ram_mc_meta_pkg;

    localparam int LH_ECDSA_META_NBITS = 64;

    function automatic int pfull_level(input int depth_nbits, input int margin);
        return (1 << depth_nbits) - margin;
    endfunction

endpackage

// File: rtl/sfifo_ram_mc_meta_if.sv
// Write/read handshake and per-channel status bundle of the multi-channel metadata FIFO.
interface sfifo_ram_mc_meta_if
    import sfifo_ram_mc_meta_pkg::*;
#(
    parameter int WIDTH       = LH_ECDSA_META_NBITS,
    parameter int NUM_CH      = 4,
    parameter int CH_NBITS    = 2,
    parameter int DEPTH_NBITS = 9
);
    logic                              wr;
    logic [CH_NBITS-1:0]               wr_ch;
    logic [WIDTH-1:0]                  din;
    logic                              rd;
    logic [CH_NBITS-1:0]               rd_ch;
    logic [WIDTH-1:0]                  dout;
    logic                              dout_valid;
    logic [CH_NBITS-1:0]               dout_ch;
    logic [NUM_CH*(DEPTH_NBITS+1)-1:0] count;
    logic [NUM_CH-1:0]                 empty;
    logic [NUM_CH-1:0]                 full;
    logic [NUM_CH-1:0]                 pfull;
    logic                              ovf_err;
    logic                              udf_err;

    modport master (
        output wr, wr_ch, din, rd, rd_ch,
        input  dout, dout_valid, dout_ch, count, empty, full, pfull, ovf_err, udf_err
    );

    modport slave (
        input  wr, wr_ch, din, rd, rd_ch,
        output dout, dout_valid, dout_ch, count, empty, full, pfull, ovf_err, udf_err
    );
endinterface

// File: rtl/sfifo_mc_chan_ctrl.sv
// Per-channel pointer/occupancy bookkeeping; flags come only from the registered count.
module sfifo_mc_chan_ctrl
    import sfifo_ram_mc_meta_pkg::*;
#(
    parameter int DEPTH_NBITS  = 9,
    parameter int PFULL_MARGIN = 8
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_sel,
    input  logic                   rd_sel,
    output logic                   wr_acc,
    output logic                   rd_acc,
    output logic [DEPTH_NBITS-1:0] wptr,
    output logic [DEPTH_NBITS-1:0] rptr,
    output logic [DEPTH_NBITS:0]   count,
    output logic                   empty,
    output logic                   full,
    output logic                   pfull
);
    localparam int CNT_W     = DEPTH_NBITS + 1;
    localparam int DEPTH     = 1 << DEPTH_NBITS;
    localparam int PFULL_LVL = pfull_level(DEPTH_NBITS, PFULL_MARGIN);

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign pfull  = (count >= CNT_W'(PFULL_LVL));
    assign wr_acc = wr_sel && !full;
    assign rd_acc = rd_sel && !empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sfifo_ram_mc_meta.sv
// Multi-channel synchronous metadata FIFO: NUM_CH logical queues in fixed regions of one
// shared RAM, one write and one read per cycle, registered read data with channel tag.
module sfifo_ram_mc_meta
    import sfifo_ram_mc_meta_pkg::*;
#(
    parameter int WIDTH        = LH_ECDSA_META_NBITS,
    parameter int NUM_CH       = 4,
    parameter int CH_NBITS     = 2,
    parameter int DEPTH_NBITS  = 9,
    parameter int PFULL_MARGIN = 8
)
(
    input  logic              clk,
    input  logic              rst,
    sfifo_ram_mc_meta_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_NBITS;
    localparam int CNT_W = DEPTH_NBITS + 1;
    localparam int AW    = CH_NBITS + DEPTH_NBITS;

    logic [NUM_CH-1:0]      wr_acc, rd_acc, empty_v, full_v, pfull_v;
    logic [DEPTH_NBITS-1:0] wptr [NUM_CH];
    logic [DEPTH_NBITS-1:0] rptr [NUM_CH];
    logic [CNT_W-1:0]       cnt  [NUM_CH];
    logic [AW-1:0]          waddr, raddr;
    logic                   wr_any, rd_any;

    (* ram_style = "ultra" *) logic [WIDTH-1:0] ram [NUM_CH*DEPTH];

    logic [WIDTH-1:0]    dout_p1;
    logic                vld_p1;
    logic [CH_NBITS-1:0] ch_p1;
    logic                ovf_q, udf_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sfifo_mc_chan_ctrl #(
            .DEPTH_NBITS  (DEPTH_NBITS),
            .PFULL_MARGIN (PFULL_MARGIN)
        ) u_ctrl (
            .clk    (clk),
            .rst    (rst),
            .wr_sel (bus.wr && (bus.wr_ch == CH_NBITS'(c))),
            .rd_sel (bus.rd && (bus.rd_ch == CH_NBITS'(c))),
            .wr_acc (wr_acc[c]),
            .rd_acc (rd_acc[c]),
            .wptr   (wptr[c]),
            .rptr   (rptr[c]),
            .count  (cnt[c]),
            .empty  (empty_v[c]),
            .full   (full_v[c]),
            .pfull  (pfull_v[c])
        );
        assign bus.count[c*CNT_W +: CNT_W] = cnt[c];
    end

    assign wr_any = |wr_acc;
    assign rd_any = |rd_acc;
    assign waddr  = {bus.wr_ch, wptr[bus.wr_ch]};
    assign raddr  = {bus.rd_ch, rptr[bus.rd_ch]};

    always_ff @(posedge clk) begin
        if (wr_any) ram[waddr] <= bus.din;
    end

    // Stage p1: registered read data; old contents win on a same-address write.
    always_ff @(posedge clk) begin
        if (rd_any) dout_p1 <= ram[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            ch_p1  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            vld_p1 <= rd_any;
            if (rd_any) ch_p1 <= bus.rd_ch;
            if (bus.wr && full_v[bus.wr_ch])  ovf_q <= 1'b1;
            if (bus.rd && empty_v[bus.rd_ch]) udf_q <= 1'b1;
        end
    end

    assign bus.dout       = dout_p1;
    assign bus.dout_valid = vld_p1;
    assign bus.dout_ch    = ch_p1;
    assign bus.empty      = empty_v;
    assign bus.full       = full_v;
    assign bus.pfull      = pfull_v;
    assign bus.ovf_err    = ovf_q;
    assign bus.udf_err    = udf_q;
endmodule

// File: tb/tb_sfifo_ram_mc_meta.sv
// Randomized self-checking bench for sfifo_ram_mc_meta against per-channel queue model.
module tb_sfifo_ram_mc_meta;
    import sfifo_ram_mc_meta_pkg::*;

    localparam int WIDTH = LH_ECDSA_META_NBITS;
    localparam int NUM_CH = 4;
    localparam int CH_NBITS = 2;
    localparam int DEPTH_NBITS = 9;
    localparam int PFULL_MARGIN = 8;
    localparam int DEPTH = 1 << DEPTH_NBITS;
    localparam int CNT_W = DEPTH_NBITS + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq [NUM_CH][$];
    bit m_ovf, m_udf;

    sfifo_ram_mc_meta_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CH_NBITS(CH_NBITS),
                           .DEPTH_NBITS(DEPTH_NBITS)) bus ();

    sfifo_ram_mc_meta #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CH_NBITS(CH_NBITS),
                        .DEPTH_NBITS(DEPTH_NBITS), .PFULL_MARGIN(PFULL_MARGIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input bit evld, input logic [WIDTH-1:0] edat, input int ech);
        chk("dout_valid", WIDTH'(bus.dout_valid), WIDTH'(evld));
        if (evld) begin
            chk("dout", bus.dout, edat);
            chk("dout_ch", WIDTH'(bus.dout_ch), WIDTH'(ech));
        end
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("count%0d", c), WIDTH'(bus.count[c*CNT_W +: CNT_W]), WIDTH'(mq[c].size()));
            chk($sformatf("empty%0d", c), WIDTH'(bus.empty[c]), WIDTH'(mq[c].size() == 0));
            chk($sformatf("full%0d", c), WIDTH'(bus.full[c]), WIDTH'(mq[c].size() == DEPTH));
            chk($sformatf("pfull%0d", c), WIDTH'(bus.pfull[c]),
                WIDTH'(mq[c].size() >= DEPTH - PFULL_MARGIN));
        end
        chk("ovf_err", WIDTH'(bus.ovf_err), WIDTH'(m_ovf));
        chk("udf_err", WIDTH'(bus.udf_err), WIDTH'(m_udf));
    endtask

    task automatic cycle(input bit w, input int wc, input logic [WIDTH-1:0] d,
                         input bit r, input int rc, output logic [WIDTH-1:0] got);
        bit wa, ra;
        logic [WIDTH-1:0] popped;
        popped = '0;
        bus.wr = w; bus.wr_ch = CH_NBITS'(wc); bus.din = d;
        bus.rd = r; bus.rd_ch = CH_NBITS'(rc);
        wa = w && (mq[wc].size() < DEPTH);
        ra = r && (mq[rc].size() > 0);
        @(posedge clk);
        if (w && !wa) m_ovf = 1'b1;
        if (r && !ra) m_udf = 1'b1;
        if (ra) popped = mq[rc].pop_front();
        if (wa) mq[wc].push_back(d);
        #1;
        bus.wr = 1'b0; bus.rd = 1'b0;
        check_state(ra, popped, rc);
        got = bus.dout;
    endtask

    task automatic reset_cycle(input bit r, input int rc);
        rst = 1'b1;
        bus.wr = 1'b0;
        bus.rd = r; bus.rd_ch = CH_NBITS'(rc);
        @(posedge clk);
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        m_ovf = 1'b0; m_udf = 1'b0;
        #1;
        rst = 1'b0; bus.rd = 1'b0;
        check_state(1'b0, '0, 0);
        chk("rst_dout_ch", WIDTH'(bus.dout_ch), '0);
    endtask

    function automatic logic [WIDTH-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [WIDTH-1:0] g;
        bus.wr = 1'b0; bus.rd = 1'b0; bus.wr_ch = '0; bus.rd_ch = '0; bus.din = '0;
        m_ovf = 1'b0; m_udf = 1'b0;
        #2;
        reset_cycle(1'b0, 0);

        // Simple write/read on channel 2.
        cycle(1, 2, 'hA, 0, 0, g);
        cycle(1, 2, 'hB, 0, 0, g);
        cycle(0, 0, '0, 1, 2, g);
        chk("t1_first", g, 'hA);
        cycle(0, 0, '0, 1, 2, g);
        chk("t1_second", g, 'hB);

        // Fill channel 0 to full, then one extra write.
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, rnd(), 0, 0, g);
        chk("t2_full0", WIDTH'(bus.full[0]), 1);
        cycle(1, 0, rnd(), 0, 0, g);
        chk("t2_ovf", WIDTH'(bus.ovf_err), 1);

        // Underflow on channel 1 with simultaneous write.
        cycle(1, 1, 'h5, 1, 1, g);
        chk("t3_udf", WIDTH'(bus.udf_err), 1);
        cycle(0, 0, '0, 1, 1, g);
        chk("t3_data", g, 'h5);

        // Full channel 0: read and write together.
        cycle(1, 0, rnd(), 1, 0, g);
        chk("t5_count0", WIDTH'(bus.count[0 +: CNT_W]), DEPTH - 1);

        // Steady-state interleave on channel 3 across pointer wraps.
        for (int i = 0; i < 3; i++) cycle(1, 3, rnd(), 0, 0, g);
        for (int i = 0; i < 2000; i++) cycle(1, 3, rnd(), 1, 3, g);
        chk("t4_count3", WIDTH'(bus.count[3*CNT_W +: CNT_W]), 3);

        // Random traffic on all channels.
        for (int i = 0; i < 1500; i++)
            cycle(bit'($urandom_range(0, 1)), $urandom_range(0, NUM_CH - 1), rnd(),
                  bit'($urandom_range(0, 1)), $urandom_range(0, NUM_CH - 1), g);

        // Reset with entries in channel 1 and a read in flight.
        reset_cycle(1'b0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 1, rnd(), 0, 0, g);
        cycle(0, 0, '0, 1, 2, g);
        reset_cycle(1'b1, 1);
        cycle(1, 1, 'h77, 0, 0, g);
        cycle(0, 0, '0, 1, 1, g);
        chk("t6_after_rst", g, 'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
